shift_seq_ctrl: RTL and testbench

Sequencer that drives the N-bit serial-in/parallel-out shift_register.
- Accepts a parallel word on a valid/ready handshake, clears the register, then serialises the word onto the register's din one bit per enabled cycle.
- Captures the register's parallel readback, checks it against the expected word and presents it on a valid/ready output.
- Sits between the host-side word interface and the shift_register instance; it is the register's only writer.

---
 rtl/shift_ctrl_pkg.sv | 31 +++
 rtl/shift_seq_ctrl_counter.sv | 24 ++
 rtl/shift_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared types and helpers for the shift_register sequencer.
package shift_ctrl_pkg;

    localparam int unsigned WORD_CNT_W = 16;
    // Widest word the bitrev helper handles.
    localparam int unsigned MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        SETTLE,
        OUT
    } state_t;

    // Reverse the low n bits of x; bits above n come back as zero.
    function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] x, input int unsigned n);
        logic [MAX_W-1:0] r;
        logic [MAX_W-1:0] s;
        r = '0;
        s = x;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < n) begin
                r = {r[MAX_W-2:0], s[0]};
                s = s >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_counter.sv
// Bit counter for the SHIFT phase: sync clear, enable, terminal count at N-1.
module shift_bit_counter #(
    parameter  int unsigned N     = 32,
    localparam int unsigned CNT_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc_c
);

    assign tc_c = (cnt == CNT_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer that clears, serially loads and reads back an N-bit SIPO shift_register.
// N is limited to shift_ctrl_pkg::MAX_W by the bit-reverse helper.
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter  int unsigned N         = 32,
    parameter  bit          MSB_FIRST = 1'b1,
    localparam int unsigned CNT_W     = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_data,
    output logic                  sr_din,
    output logic                  sr_shift_en,
    output logic                  sr_clr,
    input  logic [N-1:0]          sr_data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          out_data,
    output logic                  busy,
    output logic                  err,
    input  logic                  err_clr,
    output logic [WORD_CNT_W-1:0] word_cnt
);

    state_t                  state_q, state_d;
    logic [N-1:0]            word_q, word_d;
    logic [N-1:0]            out_data_d;
    logic [N-1:0]            expected_c;
    logic                    err_d;
    logic [WORD_CNT_W-1:0]   word_cnt_d;
    logic                    sr_din_d, sr_shift_en_d, sr_clr_d, out_valid_d, busy_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        nidx_c;
    logic [CNT_W-1:0]        bit_idx_c;
    logic                    cnt_tc_c, cnt_clr_c, cnt_en_c;

    shift_bit_counter #(.N(N)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr_c),
        .en   (cnt_en_c),
        .cnt  (cnt_q),
        .tc_c (cnt_tc_c)
    );

    assign in_ready   = (state_q == IDLE) && !rst;
    assign expected_c = MSB_FIRST ? word_q : N'(bitrev(MAX_W'(word_q), N));

    // Next state and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        out_data_d = out_data;
        err_d      = err;
        word_cnt_d = word_cnt;
        cnt_clr_c  = 1'b0;
        cnt_en_c   = 1'b0;
        nidx_c     = '0;

        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    word_d  = in_data;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_clr_c = 1'b1;
                state_d   = SHIFT;
            end
            SHIFT: begin
                cnt_en_c = 1'b1;
                if (cnt_tc_c) begin
                    state_d = SETTLE;
                end else begin
                    nidx_c = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                out_data_d = sr_data_out;
                if (sr_data_out != expected_c) begin
                    err_d = 1'b1;
                end
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    word_cnt_d = word_cnt + WORD_CNT_W'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // sr_din is registered, so it is selected with the index of the bit shifted next cycle.
        bit_idx_c     = MSB_FIRST ? (CNT_W'(N - 1) - nidx_c) : nidx_c;
        sr_clr_d      = (state_d == CLEAR);
        sr_shift_en_d = (state_d == SHIFT);
        sr_din_d      = sr_shift_en_d && word_q[bit_idx_c];
        out_valid_d   = (state_d == OUT);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            sr_din      <= 1'b0;
            sr_shift_en <= 1'b0;
            sr_clr      <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
            word_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            sr_din      <= sr_din_d;
            sr_shift_en <= sr_shift_en_d;
            sr_clr      <= sr_clr_d;
            out_valid   <= out_valid_d;
            out_data    <= out_data_d;
            busy        <= busy_d;
            err         <= err_d;
            word_cnt    <= word_cnt_d;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl driving modelled shift registers (N=32 MSB-first, N=8 LSB-first).
module tb_shift_seq_ctrl;

    localparam int unsigned N  = 32;
    localparam int unsigned N8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready, sr_din, sr_shift_en, sr_clr;
    logic          out_valid, out_ready, busy, err, err_clr;
    logic [N-1:0]  in_data, sr_data_out, out_data, sr_q, fault_mask;
    logic [15:0]   word_cnt;

    logic          b_in_valid, b_in_ready, b_sr_din, b_sr_shift_en, b_sr_clr;
    logic          b_out_valid, b_out_ready, b_busy, b_err, b_err_clr;
    logic [N8-1:0] b_in_data, b_sr_data_out, b_out_data, b_q;
    logic [15:0]   b_word_cnt;

    shift_seq_ctrl #(.N(N), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sr_din(sr_din), .sr_shift_en(sr_shift_en), .sr_clr(sr_clr), .sr_data_out(sr_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
        .err(err), .err_clr(err_clr), .word_cnt(word_cnt)
    );

    shift_seq_ctrl #(.N(N8), .MSB_FIRST(1'b0)) dut8 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .sr_din(b_sr_din), .sr_shift_en(b_sr_shift_en), .sr_clr(b_sr_clr), .sr_data_out(b_sr_data_out),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy),
        .err(b_err), .err_clr(b_err_clr), .word_cnt(b_word_cnt)
    );

    // Shift register models: shift toward MSB, din enters bit 0, clear wins.
    always @(posedge clk) begin
        if (sr_clr) sr_q <= '0;
        else if (sr_shift_en) sr_q <= {sr_q[N-2:0], sr_din};
        if (b_sr_clr) b_q <= '0;
        else if (b_sr_shift_en) b_q <= {b_q[N8-2:0], b_sr_din};
    end
    assign sr_data_out   = sr_q & ~fault_mask;
    assign b_sr_data_out = b_q;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[3'(7 - i)] = w[3'(i)];
        return r;
    endfunction

    typedef struct {
        logic [N-1:0] word;
        logic [N-1:0] exp_data;
        logic         exp_err;
        int unsigned  acc_cyc;
    } exp_t;

    exp_t        sb[$];
    bit          sr_bits[$];
    logic        err_model = 1'b0;
    int unsigned wc_model  = 0;
    int unsigned cyc       = 0;
    int unsigned hs_cyc    = 0;
    bit          prev_pend = 1'b0;
    bit          b2b_chk   = 1'b0;
    bit          rand_ready = 1'b0;
    logic [N-1:0] held_data;

    // Monitor: model expectations are pushed at accept and popped at the output handshake.
    always @(negedge clk) begin
        exp_t         e;
        logic [N-1:0] got;
        cyc++;
        if (rst) begin
            sb.delete();
            sr_bits.delete();
            err_model = 1'b0;
            wc_model  = 0;
            prev_pend = 1'b0;
        end else begin
            if (sr_shift_en && sr_clr) begin
                mismatched++;
                $display("FAIL clr_shift_overlap: got both high at cycle %0d expected exclusive", cyc);
            end
            if (sr_shift_en) sr_bits.push_back(sr_din);
            if (err_clr) err_model = 1'b0;
            if (in_valid && in_ready) begin
                if (b2b_chk) begin
                    chk("b2b_accept_gap", 64'(cyc - hs_cyc), 64'd1);
                    b2b_chk = 1'b0;
                end
                e.word     = in_data;
                e.exp_data = in_data & ~fault_mask;
                err_model  = err_model | (e.exp_data != in_data);
                e.exp_err  = err_model;
                e.acc_cyc  = cyc;
                sb.push_back(e);
            end
            if (out_valid && !prev_pend) begin
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_out_valid: got out_valid=1 expected 0 at cycle %0d", cyc);
                end else begin
                    chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(N + 3));
                    chk("shift_count", 64'(sr_bits.size()), 64'(N));
                    got = '0;
                    foreach (sr_bits[k]) got = {got[N-2:0], sr_bits[k]};
                    chk("sr_din_seq", 64'(got), 64'(sb[0].word));
                end
                sr_bits.delete();
            end
            if (out_valid && prev_pend) chk("hold_data", 64'(out_data), 64'(held_data));
            if (out_valid) chk("in_ready_low_in_out", 64'(in_ready), 64'd0);
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_data", 64'(out_data), 64'(e.exp_data));
                chk("err", 64'(err), 64'(e.exp_err));
                chk("word_cnt_at_hs", 64'(word_cnt), 64'(16'(wc_model)));
                wc_model++;
                hs_cyc = cyc;
            end
            prev_pend = out_valid && !out_ready;
            held_data = out_data;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] w, input bit hold_valid);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 500) begin tick(); n++; end
        if (n >= 500) chk("accept_timeout", 64'(in_ready), 64'd1);
        tick();
        if (!hold_valid) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || out_valid || sb.size() != 0) && n < 500) begin tick(); n++; end
        if (n >= 500) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic send8(input logic [7:0] w);
        int   n;
        bit   bits[$];
        bit   got_ov;
        logic [7:0] got;
        n = 0;
        got_ov = 1'b0;
        b_in_valid = 1'b1;
        b_in_data  = w;
        while (!b_in_ready && n < 100) begin tick(); n++; end
        tick();
        b_in_valid = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (b_sr_shift_en) bits.push_back(b_sr_din);
            if (b_out_valid) begin got_ov = 1'b1; break; end
            n++;
        end
        chk("n8_out_valid_seen", 64'(got_ov), 64'd1);
        if (got_ov) begin
            chk("n8_shift_count", 64'(bits.size()), 64'd8);
            if (bits.size() == 8) begin
                chk("n8_first_bit", 64'(bits[0]), 64'(w[0]));
                got = '0;
                foreach (bits[k]) got = {bits[k], got[7:1]};
                chk("n8_sr_din_seq", 64'(got), 64'(w));
            end
            chk("n8_out_data", 64'(b_out_data), 64'(rev8(w)));
            chk("n8_err", 64'(b_err), 64'd0);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1; err_clr = 1'b0; fault_mask = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1; b_err_clr = 1'b0;

        repeat (2) tick();
        chk("rst_sr_clr", 64'(sr_clr), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_sr_clr", 64'(sr_clr), 64'd0);
        chk("rel_sr_din", 64'(sr_din), 64'd0);
        chk("rel_shift_en", 64'(sr_shift_en), 64'd0);
        chk("rel_out_valid", 64'(out_valid), 64'd0);
        chk("rel_busy", 64'(busy), 64'd0);
        chk("rel_err", 64'(err), 64'd0);
        chk("rel_word_cnt", 64'(word_cnt), 64'd0);
        chk("rel_out_data", 64'(out_data), 64'd0);
        chk("rel_n8_in_ready", 64'(b_in_ready), 64'd1);

        // Single known word.
        send(32'hA5A50F0F, 1'b0);
        wait_idle();
        chk("word_cnt_single", 64'(word_cnt), 64'd1);

        // Back-pressure on the output.
        out_ready = 1'b0;
        send(N'($urandom), 1'b0);
        for (int n = 0; n < 100 && !out_valid; n++) tick();
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        repeat (5) tick();
        out_ready = 1'b1;
        wait_idle();
        chk("word_cnt_bp", 64'(word_cnt), 64'd2);

        // Back-to-back with in_valid held high.
        send(32'hFFFFFFFF, 1'b1);
        b2b_chk = 1'b1;
        send(32'h00000001, 1'b0);
        wait_idle();
        chk("b2b_err", 64'(err), 64'd0);

        // Reset in the middle of SHIFT at cnt=10.
        send(N'($urandom), 1'b0);
        for (int n = 0; n < 100 && !sr_shift_en; n++) tick();
        repeat (10) tick();
        rst = 1'b1;
        tick();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_shift_en", 64'(sr_shift_en), 64'd0);
        chk("midrst_word_cnt", 64'(word_cnt), 64'd0);
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("postrst_no_out_valid", 64'(out_valid), 64'd0);
        end
        send(32'h12345678, 1'b0);
        wait_idle();

        // Readback fault on bit 3, sticky err, then clear.
        fault_mask = 32'h8;
        send(32'h0000000F, 1'b0);
        wait_idle();
        fault_mask = '0;
        chk("err_sticky_idle", 64'(err), 64'(err_model));
        send(N'($urandom), 1'b0);
        wait_idle();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_after_clr", 64'(err), 64'(err_model));

        // Random words with random output back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            send(N'($urandom), 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        wait_idle();
        chk("word_cnt_final", 64'(word_cnt), 64'(16'(wc_model)));

        // N=8, LSB-first instance.
        send8(8'h01);
        for (int i = 0; i < 3; i++) send8(8'($urandom));
        chk("n8_word_cnt", 64'(b_word_cnt), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
